i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Register-file backend sitting directly downstream of i2c_slave, on the SFP-side management bus.
- Consumes i2c_slave's byte-level strobes (rxdata, ack, r, w, stop) and produces txdata for read transfers.
- Implements a standard pointer-then-data protocol: the first write byte sets the pointer, later bytes write or read with pointer auto-increment.
- Also gives fabric logic a local read/write port, so the SFP test logic can observe and preload registers.

Parameters:
- DEPTH, 16, number of 8-bit registers; power of two, minimum 4.
- ADDR_W, 4, pointer width; equals log2(DEPTH).
- RST_VAL0, 8'h05, reset value of register 0.
- RST_VAL1, 8'h06, reset value of register 1; all other registers reset to 8'h00.

Ports:
- clk  in  1  system clock; same clock as i2c_slave.
- rst  in  1  asynchronous, active-high reset.
- rxdata  in  8  byte received by i2c_slave; valid while ack is high.
- ack  in  1  high during the ACK bit of each byte, in both directions.
- w  in  1  current transfer is a master write.
- r  in  1  current transfer is a master read.
- stop  in  1  one-cycle pulse on STOP or repeated START.
- txdata  out  8  byte for i2c_slave to shift out on a read.
- host_addr  in  ADDR_W  local port address.
- host_we  in  1  local write strobe.
- host_wdata  in  8  local write data.
- host_rdata  out  8  registered read data for host_addr.
- wr_strobe  out  1  one-cycle pulse when an I2C write updates a register.
- wr_addr  out  ADDR_W  register index of the last I2C write.
- wr_data  out  8  data of the last I2C write.
- ptr  out  ADDR_W  current register pointer.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- All inputs are synchronous to clk; no synchronisers inside the block.
- Reset state:
  - reg[0]=RST_VAL0, reg[1]=RST_VAL1, all other registers 0.
  - ptr=0, state=S_PTR, ack_d=0.
  - wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0.
  - txdata=reg[0] (combinational from ptr).
- Edge detection: ack_d is ack registered; ack_rise = ack & ~ack_d. All I2C actions take effect on the clk edge where ack_rise is true, so updates are visible one cycle after ack is first sampled high.
- State machine, two states:
  - S_PTR: on ack_rise with w=1, ptr <= rxdata[ADDR_W-1:0] (upper bits ignored) and go to S_DATA. No register write occurs.
  - S_DATA: on ack_rise with w=1, reg[ptr] <= rxdata, ptr <= ptr+1 (wraps DEPTH-1 to 0), wr_strobe=1, wr_addr=old ptr, wr_data=rxdata.
  - Any state: on ack_rise with r=1 (and w=0), ptr <= ptr+1 with wrap. No state change; the pointer is not reloaded.
  - stop=1 forces state to S_PTR with ptr retained, so write-pointer / repeated-START / read works. stop has priority over a coincident ack_rise, which is ignored.
  - r and w both high: treated as a write.
- txdata: txdata = reg[ptr], combinational. A change of ptr or of the addressed register is reflected the same cycle.
- Local port:
  - host_rdata <= reg[host_addr] every cycle (1-cycle latency).
  - host_we=1 writes reg[host_addr] <= host_wdata.
  - Same cycle, same address as an I2C write: the I2C write wins and the host write is dropped. Different addresses: both writes happen.
- wr_strobe: high exactly one cycle per I2C data write; wr_addr and wr_data hold until the next write.
- Reset mid-transfer: everything returns to reset values immediately. The first ack_rise after release is treated as a pointer byte if w=1.

Test Plan:
- Reset check: assert rst, then release -> host_rdata reads 0x05 @0, 0x06 @1, 0x00 @2..15; txdata=0x05; ptr=0; wr_strobe=0.
- Write with pointer: write bytes 0x02, 0xA5, 0x5A, then stop -> reg2=0xA5, reg3=0x5A, ptr=4, two wr_strobe pulses with (addr,data)=(2,A5) then (3,5A).
- Pointer then read: write 0x01, stop, then read 3 bytes -> txdata=0x06, then reg2, then reg3; ptr ends at 4; no wr_strobe.
- Wrap-around: pointer byte 0xFF (masked to 15), then write 0x11, 0x22 -> reg15=0x11, reg0=0x22, ptr=1.
- Write collision: host_we writes 0x33 to address 3 on the same cycle as an I2C write of 0x44 to register 3 -> reg3=0x44. Host write to address 7 on that cycle -> reg7=0x33.
- Abort and reset: stop coincident with ack_rise -> no write and state=S_PTR. rst pulsed after a pointer byte -> reg0=0x05 and the next write byte is taken as a pointer.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// Pointer-then-data register file behind i2c_slave, with a local host read/write port.
// I2C actions land on the edge where ack rises; host_rdata has 1-cycle latency; there is no backpressure.
module i2c_slave_regfile #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  RST_VAL0 = 8'h05,
  parameter logic [7:0]  RST_VAL1 = 8'h06
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxdata,
  input  logic              ack,
  input  logic              w,
  input  logic              r,
  input  logic              stop,
  output logic [7:0]        txdata,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] ptr
);

  typedef enum logic {S_PTR, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ack_q;
  logic                ack_rise;
  logic                i2c_we;
  logic                host_wr_ok;
  logic [7:0]          regs_q [DEPTH];
  logic [7:0]          host_rdata_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;

  assign ack_rise = ack & ~ack_q;

  // stop wins over a coincident ack_rise; r&w together counts as a write.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    i2c_we  = 1'b0;
    if (stop) begin
      state_d = S_PTR;
    end else if (ack_rise && w) begin
      if (state_q == S_PTR) begin
        ptr_d   = rxdata[ADDR_W-1:0];
        state_d = S_DATA;
      end else begin
        i2c_we = 1'b1;
        ptr_d  = ADDR_W'(ptr_q + 1'b1);
      end
    end else if (ack_rise && r) begin
      ptr_d = ADDR_W'(ptr_q + 1'b1);
    end
  end

  assign host_wr_ok = host_we && !(i2c_we && (host_addr == ptr_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PTR;
      ptr_q       <= '0;
      ack_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack;
      wr_strobe_q <= i2c_we;
      if (i2c_we) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= rxdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
      regs_q[0]    <= RST_VAL0;
      regs_q[1]    <= RST_VAL1;
      host_rdata_q <= 8'h00;
    end else begin
      host_rdata_q <= regs_q[host_addr];
      if (host_wr_ok) regs_q[host_addr] <= host_wdata;
      if (i2c_we)     regs_q[ptr_q]     <= rxdata;
    end
  end

  assign txdata     = regs_q[ptr_q];
  assign host_rdata = host_rdata_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign ptr        = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: register table checks plus hand-built I2C byte sequences.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxdata;
  logic       ack, w, r, stop;
  logic [7:0] txdata;
  logic [3:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] ptr;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] sq_addr [$];
  logic [7:0] sq_data [$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t rst_tab [16];

  i2c_slave_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .rxdata     (rxdata),
    .ack        (ack),
    .w          (w),
    .r          (r),
    .stop       (stop),
    .txdata     (txdata),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      sq_addr.push_back(wr_addr);
      sq_data.push_back(wr_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    @(negedge clk);
    check(name, {24'h0, host_rdata}, {24'h0, exp});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_w);
    rxdata = b;
    w      = is_w;
    r      = ~is_w;
    ack    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    w    = 1'b0;
    r    = 1'b0;
    @(negedge clk);
  endtask

  task automatic collide(input logic [7:0] b, input logic [3:0] ha, input logic [7:0] hd);
    rxdata     = b;
    w          = 1'b1;
    r          = 1'b0;
    ack        = 1'b1;
    host_we    = 1'b1;
    host_addr  = ha;
    host_wdata = hd;
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rst_tab[i].addr = 4'(i);
      rst_tab[i].exp  = 8'h00;
    end
    rst_tab[0].exp = 8'h05;
    rst_tab[1].exp = 8'h06;

    rst = 1'b1; rxdata = 8'h00; ack = 1'b0; w = 1'b0; r = 1'b0; stop = 1'b0;
    host_addr = 4'h0; host_we = 1'b0; host_wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ptr", {28'h0, ptr}, 32'h0);
    check("rst_txdata", {24'h0, txdata}, 32'h05);
    check("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data}, 32'h0);
    for (int i = 0; i < 16; i++)
      chk_reg($sformatf("rst_reg%0d", i), rst_tab[i].addr, rst_tab[i].exp);

    // Pointer byte then two data writes
    sq_addr.delete(); sq_data.delete();
    send_byte(8'h02, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    do_stop();
    chk_reg("wr_reg2", 4'd2, 8'hA5);
    chk_reg("wr_reg3", 4'd3, 8'h5A);
    check("wr_ptr", {28'h0, ptr}, 32'h4);
    check("wr_strobe_cnt", sq_addr.size(), 32'd2);
    if (sq_addr.size() == 2) begin
      check("wr_strobe0_addr", {28'h0, sq_addr[0]}, 32'h2);
      check("wr_strobe0_data", {24'h0, sq_data[0]}, 32'hA5);
      check("wr_strobe1_addr", {28'h0, sq_addr[1]}, 32'h3);
      check("wr_strobe1_data", {24'h0, sq_data[1]}, 32'h5A);
    end
    check("wr_addr_hold", {28'h0, wr_addr}, 32'h3);
    check("wr_data_hold", {24'h0, wr_data}, 32'h5A);

    // Pointer write, repeated start, three reads
    sq_addr.delete(); sq_data.delete();
    send_byte(8'h01, 1'b1);
    do_stop();
    check("rd_tx0", {24'h0, txdata}, 32'h06);
    send_byte(8'h00, 1'b0);
    check("rd_tx1", {24'h0, txdata}, 32'hA5);
    send_byte(8'h00, 1'b0);
    check("rd_tx2", {24'h0, txdata}, 32'h5A);
    send_byte(8'h00, 1'b0);
    do_stop();
    check("rd_ptr", {28'h0, ptr}, 32'h4);
    check("rd_no_strobe", sq_addr.size(), 32'd0);

    // Pointer masked to 15, writes wrap to register 0
    send_byte(8'hFF, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_stop();
    chk_reg("wrap_reg15", 4'd15, 8'h11);
    chk_reg("wrap_reg0", 4'd0, 8'h22);
    check("wrap_ptr", {28'h0, ptr}, 32'h1);

    // Host/I2C write collisions
    send_byte(8'h03, 1'b1);
    collide(8'h44, 4'd3, 8'h33);
    collide(8'h55, 4'd7, 8'h33);
    do_stop();
    chk_reg("coll_reg3", 4'd3, 8'h44);
    chk_reg("coll_reg4", 4'd4, 8'h55);
    chk_reg("coll_reg7", 4'd7, 8'h33);

    // stop coincident with ack_rise: no write, back to pointer state
    sq_addr.delete(); sq_data.delete();
    send_byte(8'h08, 1'b1);
    rxdata = 8'h77; w = 1'b1; r = 1'b0; ack = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    check("abort_ptr", {28'h0, ptr}, 32'h8);
    check("abort_no_strobe", sq_addr.size(), 32'd0);
    send_byte(8'h09, 1'b1);
    send_byte(8'h99, 1'b1);
    do_stop();
    chk_reg("abort_reg8", 4'd8, 8'h00);
    chk_reg("abort_reg9", 4'd9, 8'h99);
    check("abort_ptr2", {28'h0, ptr}, 32'hA);

    // Reset after a pointer byte
    send_byte(8'h05, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_ptr", {28'h0, ptr}, 32'h0);
    check("mid_rst_txdata", {24'h0, txdata}, 32'h05);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h0C, 1'b1);
    send_byte(8'hAB, 1'b1);
    do_stop();
    chk_reg("post_rst_reg0", 4'd0, 8'h05);
    chk_reg("post_rst_reg5", 4'd5, 8'h00);
    chk_reg("post_rst_reg3", 4'd3, 8'h00);
    chk_reg("post_rst_reg12", 4'd12, 8'hAB);
    check("post_rst_ptr", {28'h0, ptr}, 32'hD);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
